lfsr_checker: RTL and testbench

Self-synchronising receiver for the serial bit stream produced by the team's 10-bit LFSR, using recurrence `s' = {~(s[0]^s[3]), s[9:1]}`; each emitted bit is the new `s'[9]`. The block seeds a local copy of the LFSR from the incoming bits and then verifies the stream. Once locked, it free-runs that copy, reports mismatches as bit errors, and drops lock on sustained loss. It sits at the far end of a PRBS link or data path for built-in self-test.

---
 rtl/lfsr_checker.sv | 126 ++++++++++++
 tb/tb_lfsr_checker.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// Self-synchronising PRBS checker for the 10-bit XNOR LFSR s' = {~(s[0]^s[3]), s[9:1]}.
// Seeds from the received stream, verifies, then flywheels and counts bit errors while locked.
module lfsr_checker #(
    parameter int LOCK_THRESH = 16,
    parameter int LOSS_THRESH = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);
    localparam logic [1:0] ST_SEED   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam int GW = $clog2(LOCK_THRESH + 1);
    localparam int BW = $clog2(LOSS_THRESH + 1);
    localparam logic [GW-1:0] LOCK_MAX = GW'(LOCK_THRESH);
    localparam logic [GW-1:0] LOCK_M1  = GW'(LOCK_THRESH - 1);
    localparam logic [BW-1:0] LOSS_MAX = BW'(LOSS_THRESH);
    localparam logic [BW-1:0] LOSS_M1  = BW'(LOSS_THRESH - 1);

    logic [1:0]       r_state;
    logic [9:0]       r_shreg;
    logic [3:0]       r_fill_cnt;
    logic [GW-1:0]    r_good_cnt;
    logic [BW-1:0]    r_bad_run;
    logic             r_err_pulse;
    logic [CNT_W-1:0] r_err_count;
    logic [CNT_W-1:0] r_bit_count;

    logic             w_pred;
    logic             w_mismatch;
    logic [9:0]       w_shift_rx;
    logic             w_bit_inc;
    logic             w_err_inc;
    logic [CNT_W-1:0] w_err_base;
    logic [CNT_W-1:0] w_bit_base;

    assign w_pred     = ~(r_shreg[0] ^ r_shreg[3]);
    assign w_mismatch = bit_in != w_pred;
    assign w_shift_rx = {bit_in, r_shreg[9:1]};
    assign w_bit_inc  = bit_valid && (r_state == ST_LOCKED);
    assign w_err_inc  = w_bit_inc && w_mismatch;

    // Clear takes effect before a same-cycle increment.
    assign w_err_base = err_clr ? '0 : r_err_count;
    assign w_bit_base = err_clr ? '0 : r_bit_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_SEED;
            r_shreg     <= '0;
            r_fill_cnt  <= '0;
            r_good_cnt  <= '0;
            r_bad_run   <= '0;
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
            r_bit_count <= '0;
        end else begin
            r_err_pulse <= 1'b0;
            r_err_count <= (w_err_inc && (w_err_base != '1)) ? w_err_base + 1'b1 : w_err_base;
            r_bit_count <= (w_bit_inc && (w_bit_base != '1)) ? w_bit_base + 1'b1 : w_bit_base;
            if (bit_valid) begin
                case (r_state)
                    ST_SEED: begin
                        r_shreg <= w_shift_rx;
                        if (r_fill_cnt == 4'd9) begin
                            // All-ones is the XNOR lock-up state; never verify from it.
                            if (w_shift_rx == 10'h3FF) begin
                                r_fill_cnt <= '0;
                            end else begin
                                r_fill_cnt <= 4'd10;
                                r_good_cnt <= '0;
                                r_state    <= ST_VERIFY;
                            end
                        end else begin
                            r_fill_cnt <= r_fill_cnt + 4'd1;
                        end
                    end
                    ST_VERIFY: begin
                        r_shreg <= w_shift_rx;
                        if ((r_shreg == 10'h3FF) || w_mismatch) begin
                            r_fill_cnt <= '0;
                            r_state    <= ST_SEED;
                        end else if (r_good_cnt == LOCK_M1) begin
                            r_good_cnt <= LOCK_MAX;
                            r_bad_run  <= '0;
                            r_state    <= ST_LOCKED;
                        end else begin
                            r_good_cnt <= r_good_cnt + 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        // Flywheel: the received bit never enters the local LFSR.
                        r_shreg <= {w_pred, r_shreg[9:1]};
                        if (w_mismatch) begin
                            r_err_pulse <= 1'b1;
                            if (r_bad_run == LOSS_M1) begin
                                r_bad_run  <= LOSS_MAX;
                                r_fill_cnt <= '0;
                                r_state    <= ST_SEED;
                            end else begin
                                r_bad_run <= r_bad_run + 1'b1;
                            end
                        end else begin
                            r_bad_run <= '0;
                        end
                    end
                    default: r_state <= ST_SEED;
                endcase
            end
        end
    end

    assign locked    = (r_state == ST_LOCKED);
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;
    assign bit_count = r_bit_count;
endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: directed scenarios with literal expectations plus a randomized
// run, all outputs compared every cycle against a behavioural reference model.
module tb_lfsr_checker;
    localparam int LOCK = 16;
    localparam int LOSS = 4;
    localparam int CW   = 8;
    localparam int SAT  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          bit_in = 1'b0;
    logic          bit_valid = 1'b0;
    logic          err_clr = 1'b0;
    logic          locked;
    logic          err_pulse;
    logic [CW-1:0] err_count;
    logic [CW-1:0] bit_count;

    lfsr_checker #(.LOCK_THRESH(LOCK), .LOSS_THRESH(LOSS), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .err_clr(err_clr),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .bit_count(bit_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: seeding collects raw bits in a queue, the LFSR is stepped as a function.
    function automatic logic [9:0] step(input logic [9:0] s);
        return {~(s[0] ^ s[3]), s[9:1]};
    endfunction

    bit         started = 0;
    int         m_mode;           // 0 seed, 1 verify, 2 locked
    logic       m_q[$];
    logic [9:0] m_s;
    int         m_good, m_bad, m_err, m_bits;
    logic       m_pulse;

    task automatic model_step();
        logic [9:0] nxt;
        logic [9:0] v;
        if (reset) begin
            started = 1; m_mode = 0; m_q.delete(); m_s = '0;
            m_good = 0; m_bad = 0; m_err = 0; m_bits = 0; m_pulse = 0;
            return;
        end
        m_pulse = 0;
        if (err_clr) begin m_err = 0; m_bits = 0; end
        if (!bit_valid) return;
        nxt = step(m_s);
        if (m_mode == 0) begin
            m_q.push_back(bit_in);
            if (m_q.size() == 10) begin
                for (int i = 0; i < 10; i++) v[i] = m_q[i];
                m_q.delete();
                if (v != 10'h3FF) begin m_s = v; m_mode = 1; m_good = 0; end
            end
        end else if (m_mode == 1) begin
            if (m_s == 10'h3FF || bit_in != nxt[9]) m_mode = 0;
            else begin
                m_s = nxt; m_good++;
                if (m_good == LOCK) begin m_mode = 2; m_bad = 0; end
            end
        end else begin
            m_s = nxt;
            if (m_bits < SAT) m_bits++;
            if (bit_in != nxt[9]) begin
                m_pulse = 1; m_bad++;
                if (m_err < SAT) m_err++;
                if (m_bad == LOSS) m_mode = 0;
            end else m_bad = 0;
        end
    endtask

    task automatic compare_all();
        check("cmp_locked", int'(locked), int'(m_mode == 2));
        check("cmp_err_pulse", int'(err_pulse), int'(m_pulse));
        check("cmp_err_count", int'(err_count), m_err);
        check("cmp_bit_count", int'(bit_count), m_bits);
    endtask

    always @(posedge clk) model_step();
    always @(negedge clk) if (started) compare_all();

    // Stimulus: inputs change on the falling edge, DUT and model sample on the rising edge.
    logic [9:0] g_s;
    task automatic next_bit(output logic b);
        g_s = step(g_s);
        b = g_s[9];
    endtask
    task automatic tick(input logic v, input logic b, input logic c, input logic r);
        @(negedge clk);
        bit_valid = v; bit_in = b; err_clr = c; reset = r;
    endtask
    task automatic settle();
        @(posedge clk); #1;
    endtask
    task automatic clean(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin next_bit(b); tick(1, b, 0, 0); end
    endtask
    task automatic do_reset();
        tick(0, 0, 0, 1); tick(0, 0, 0, 0);
        g_s = '0;
    endtask
    // Feeds a clean lock sequence of n valid bits with 'gap' idle cycles after each one.
    task automatic lock_seq(input string nm, input int gap);
        logic b;
        for (int i = 1; i <= 10 + LOCK; i++) begin
            next_bit(b); tick(1, b, 0, 0); settle();
            if (i == 9 + LOCK) check({nm, "_unlocked_before"}, int'(locked), 0);
            if (i == 10 + LOCK) check({nm, "_locked_after"}, int'(locked), 1);
            for (int k = 0; k < gap; k++) tick(0, 0, 0, 0);
        end
    endtask

    initial begin
        logic b;
        bit   saw_lock;
        g_s = '0;
        tick(0, 0, 0, 1); tick(0, 0, 0, 1); settle();
        check("reset_locked", int'(locked), 0);
        check("reset_err_count", int'(err_count), 0);
        check("reset_bit_count", int'(bit_count), 0);
        check("reset_err_pulse", int'(err_pulse), 0);
        tick(0, 0, 0, 0);

        // Clean lock, then 100 checked bits.
        g_s = '0;
        lock_seq("t1", 0);
        clean(100); settle();
        check("t1_bit_count", int'(bit_count), 100);
        check("t1_err_count", int'(err_count), 0);

        // Single error; flywheel keeps alignment afterwards.
        next_bit(b); tick(1, ~b, 0, 0); settle();
        check("t2_pulse", int'(err_pulse), 1);
        check("t2_err_count", int'(err_count), 1);
        check("t2_locked", int'(locked), 1);
        clean(50); settle();
        check("t2_err_after", int'(err_count), 1);
        check("t2_still_locked", int'(locked), 1);

        // Four consecutive errors drop lock; then relock.
        tick(0, 0, 1, 0);
        for (int i = 1; i <= LOSS; i++) begin
            next_bit(b); tick(1, ~b, 0, 0); settle();
            if (i == LOSS - 1) check("t3_locked_3rd", int'(locked), 1);
        end
        check("t3_err_count", int'(err_count), LOSS);
        check("t3_lost", int'(locked), 0);
        check("t3_pulse", int'(err_pulse), 1);
        lock_seq("t3_relock", 0);
        check("t3_err_hold", int'(err_count), LOSS);

        // Lock-up streams.
        do_reset();
        saw_lock = 0;
        for (int i = 0; i < 200; i++) begin tick(1, 1, 0, 0); settle(); saw_lock |= locked; end
        check("t4_ones_nolock", int'(saw_lock), 0);
        check("t4_ones_err", int'(err_count), 0);
        for (int i = 0; i < 200; i++) begin tick(1, 0, 0, 0); settle(); saw_lock |= locked; end
        check("t4_zeros_nolock", int'(saw_lock), 0);
        check("t4_zeros_bits", int'(bit_count), 0);

        // Gapped stream and clears.
        do_reset();
        lock_seq("t5", 2);
        clean(5);
        next_bit(b); tick(1, ~b, 1, 0); settle();
        check("t5_clr_err_count", int'(err_count), 1);
        check("t5_clr_bit_count", int'(bit_count), 1);
        tick(0, 0, 1, 0); settle();
        check("t5_clr_only_err", int'(err_count), 0);
        check("t5_clr_only_bits", int'(bit_count), 0);
        tick(0, 0, 0, 0);

        // Reset while locked with three errors.
        do_reset();
        lock_seq("t6", 0);
        for (int k = 0; k < 3; k++) begin next_bit(b); tick(1, ~b, 0, 0); clean(3); end
        settle();
        check("t6_err3", int'(err_count), 3);
        tick(1, 0, 0, 1); settle();
        check("t6_rst_locked", int'(locked), 0);
        check("t6_rst_err", int'(err_count), 0);
        check("t6_rst_bits", int'(bit_count), 0);
        check("t6_rst_pulse", int'(err_pulse), 0);
        tick(0, 0, 0, 0);
        lock_seq("t6_relock", 0);

        // Counter saturation.
        do_reset();
        clean(10 + LOCK + 300); settle();
        check("sat_bit_count", int'(bit_count), SAT);
        check("sat_locked", int'(locked), 1);

        // Randomized: blocks of mostly-clean, error-heavy and pure-noise traffic.
        do_reset();
        for (int blk = 0; blk < 30; blk++) begin
            for (int c = 0; c < 200; c++) begin
                logic v, f, r, clr;
                r   = ($urandom_range(0, 499) == 0);
                v   = ($urandom_range(0, 3) != 0);
                clr = ($urandom_range(0, 79) == 0);
                case (blk % 3)
                    0: f = ($urandom_range(0, 39) == 0);
                    1: f = ($urandom_range(0, 2) == 0);
                    default: f = 1'($urandom_range(0, 1));
                endcase
                if (v) begin
                    next_bit(b);
                    if (blk % 3 == 2) b = 1'($urandom_range(0, 1));
                    else b = b ^ f;
                end else b = 1'($urandom_range(0, 1));
                tick(v, b, clr, r);
            end
        end
        tick(0, 0, 0, 0); settle(); settle();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
